// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: steps {A,B,C} through 0..7, samples two implementations
// of the same 3-input function, counts disagreements and compares both tables to EXPECTED.
module truth_table_sweeper #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [7:0]  EXPECTED = 8'h51
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       y_gate,
    input  logic       y_op,
    output logic [2:0] abc,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] mismatch_count,
    output logic [7:0] tt_gate,
    output logic [7:0] tt_op
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t     state, stateNext;
    logic [2:0] index;
    logic [3:0] settleCnt;
    logic [7:0] ttGateNext, ttOpNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = WAIT;
            WAIT:    if (settleCnt == LAST_CNT) stateNext = SAMPLE;
            SAMPLE:  stateNext = (index == 3'd7) ? DONE : WAIT;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == WAIT) || (state == SAMPLE);
        done = (state == DONE);
    end

    // Tables including the current sample, so pass is valid in the DONE cycle itself.
    always_comb begin
        ttGateNext        = tt_gate;
        ttOpNext          = tt_op;
        ttGateNext[index] = y_gate;
        ttOpNext[index]   = y_op;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abc            <= '0;
            index          <= '0;
            settleCnt      <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            tt_gate        <= '0;
            tt_op          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        abc            <= '0;
                        index          <= '0;
                        settleCnt      <= '0;
                        pass           <= 1'b0;
                        mismatch_count <= '0;
                        tt_gate        <= '0;
                        tt_op          <= '0;
                    end
                end
                WAIT: begin
                    if (settleCnt == LAST_CNT) settleCnt <= '0;
                    else                       settleCnt <= settleCnt + 4'd1;
                end
                SAMPLE: begin
                    tt_gate <= ttGateNext;
                    tt_op   <= ttOpNext;
                    if (y_gate != y_op) mismatch_count <= mismatch_count + 4'd1;
                    if (index == 3'd7) begin
                        pass <= (ttGateNext == EXPECTED) && (ttOpNext == EXPECTED);
                    end else begin
                        index <= index + 3'd1;
                        abc   <= abc + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3) fed from lookup tables,
// results compared to expectations computed from the tables with plain arithmetic.
module tb_truth_table_sweeper;

    localparam logic [7:0] EXP_TT = 8'h51;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start3;
    logic [7:0] tblG, tblO;

    logic [2:0] abc1, abc3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [3:0] mc1, mc3;
    logic [7:0] ttG1, ttG3, ttO1, ttO3;
    logic       yG1, yO1, yG3, yO3;

    logic       sel;
    logic [2:0] abcV;
    logic       busyV, doneV, passV;
    logic [3:0] mcV;
    logic [7:0] ttGV, ttOV;

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    assign yG1 = tblG[abc1];
    assign yO1 = tblO[abc1];
    assign yG3 = tblG[abc3];
    assign yO3 = tblO[abc3];

    always_comb begin
        abcV  = sel ? abc3  : abc1;
        busyV = sel ? busy3 : busy1;
        doneV = sel ? done3 : done1;
        passV = sel ? pass3 : pass1;
        mcV   = sel ? mc3   : mc1;
        ttGV  = sel ? ttG3  : ttG1;
        ttOV  = sel ? ttO3  : ttO1;
    end

    truth_table_sweeper #(.SETTLE(1), .EXPECTED(EXP_TT)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .y_gate(yG1), .y_op(yO1),
        .abc(abc1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_count(mc1), .tt_gate(ttG1), .tt_op(ttO1)
    );

    truth_table_sweeper #(.SETTLE(3), .EXPECTED(EXP_TT)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .y_gate(yG3), .y_op(yO3),
        .abc(abc3), .busy(busy3), .done(done3), .pass(pass3),
        .mismatch_count(mc3), .tt_gate(ttG3), .tt_op(ttO3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setStart(input logic v);
        if (sel) start3 = v;
        else     start1 = v;
    endtask

    // Runs one sweep on the selected instance, checking abc/busy/done every cycle and the
    // results in the DONE cycle. Returns #1 after the edge that leaves DONE.
    task automatic runSweep(input bit useS3, input logic [7:0] g, input logic [7:0] o,
                            input bit pulseBusy, input bit holdEnd, input bit preAcc);
        int unsigned per;
        int unsigned total;
        int unsigned expAbc;
        logic [3:0]  expMc;
        logic        expPass;
        sel     = useS3;
        per     = useS3 ? 4 : 2;
        total   = 8 * per;
        tblG    = g;
        tblO    = o;
        expMc   = 4'($countones(g ^ o));
        expPass = (g == EXP_TT) && (o == EXP_TT);
        if (!preAcc) begin
            setStart(1'b1);
            @(posedge clk); #1;
            setStart(1'b0);
            check("accept_busy", busyV, 1);
            check("accept_abc", abcV, 0);
            check("accept_pass", passV, 0);
            check("accept_mc", mcV, 0);
            check("accept_tt", {ttGV, ttOV}, 0);
        end
        for (int unsigned k = 1; k <= total; k++) begin
            @(posedge clk); #1;
            expAbc = (k / per > 7) ? 7 : k / per;
            check("abc_step", abcV, expAbc);
            if (k < total) begin
                check("busy_run", busyV, 1);
                check("done_early", doneV, 0);
            end else begin
                check("done_pulse", doneV, 1);
                check("busy_done", busyV, 0);
                check("tt_gate", ttGV, g);
                check("tt_op", ttOV, o);
                check("mismatch", mcV, expMc);
                check("pass", passV, expPass);
            end
            if (pulseBusy && k == 4) setStart(1'b1);
            if (pulseBusy && k == 5) setStart(1'b0);
            if (holdEnd && k == total - 1) setStart(1'b1);
        end
        @(posedge clk); #1;
        check("done_width", doneV, 0);
        check("idle_busy", busyV, 0);
        check("idle_abc", abcV, 7);
        check("pass_hold", passV, expPass);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        sel    = 1'b0;
        tblG   = EXP_TT;
        tblO   = EXP_TT;
        repeat (3) @(posedge clk);
        #1;
        check("rst_abc", {abc1, abc3}, 0);
        check("rst_flags", {busy1, done1, pass1, busy3, done3, pass3}, 0);
        check("rst_mc", {mc1, mc3}, 0);
        check("rst_tt", {ttG1, ttO1, ttG3, ttO3}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        runSweep(0, 8'h51, 8'h51, 0, 0, 0);
        runSweep(0, 8'h51, 8'h00, 0, 0, 0);
        runSweep(0, 8'hAE, 8'hAE, 0, 0, 0);

        // start re-pulsed mid-sweep, then held through DONE
        runSweep(0, 8'h51, 8'h51, 1, 1, 0);
        @(posedge clk); #1;
        setStart(1'b0);
        check("held_restart_busy", busyV, 1);
        check("held_restart_pass", passV, 0);
        check("held_restart_abc", abcV, 0);
        check("held_restart_tt", {ttGV, ttOV}, 0);
        runSweep(0, 8'h51, 8'h51, 0, 0, 1);

        // reset during SAMPLE of vector 4
        sel    = 1'b0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_rst_abc", abc1, 4);
        check("pre_rst_busy", busy1, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_abc", abc1, 0);
        check("midrst_flags", {busy1, done1, pass1}, 0);
        check("midrst_mc", mc1, 0);
        check("midrst_tt", {ttG1, ttO1}, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_nodone", {done1, busy1}, 0);
        end
        reset = 1'b0;
        runSweep(0, 8'h51, 8'h51, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            runSweep(0, 8'($urandom), 8'($urandom), 0, 0, 0);
        end

        runSweep(1, 8'h51, 8'h51, 0, 0, 0);
        runSweep(1, 8'h51, 8'h00, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            runSweep(1, 8'($urandom), 8'($urandom), 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
